// File: rtl/pe_sequencer.sv
// Instruction sequencer for the SIMD PE array: program/operand/result banks, host load port,
// PC stepping with pe_ready stall, single-level hardware loop and stage-1/stage-2 result capture.
module pe_sequencer #(
  parameter int DATA_LEN      = 32,
  parameter int PE_ELEMENTS   = 4,
  parameter int INST_LEN      = 16,
  parameter int OPCODE_LEN    = 4,
  parameter int PE_OPCODE_LEN = 4,
  parameter int ADDR_LEN      = 8,
  parameter int IMEM_DEPTH    = 128,
  parameter int DMEM_DEPTH    = 64
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              pe_ready,
  input  logic                              pe_stage_1_valid,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0]   pe_stage_1_output,
  input  logic                              pe_stage_2_valid,
  input  logic [DATA_LEN-1:0]               pe_stage_2_output,
  input  logic                              store_result,
  input  logic                              mem_we,
  input  logic [1:0]                        mem_sel,
  input  logic [$clog2(IMEM_DEPTH)-1:0]     mem_addr,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0]   mem_wdata,
  input  logic [$clog2(DMEM_DEPTH)-1:0]     rd_addr,
  output logic [PE_ELEMENTS*DATA_LEN-1:0]   rd_data,
  output logic [PE_OPCODE_LEN-1:0]          pe_opcode,
  output logic                              pe_opcode_valid,
  output logic [PE_ELEMENTS*DATA_LEN-1:0]   data_a,
  output logic [PE_ELEMENTS*DATA_LEN-1:0]   data_b,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int VEC_LEN = PE_ELEMENTS * DATA_LEN;
  localparam int IAW     = $clog2(IMEM_DEPTH);
  localparam int DAW     = $clog2(DMEM_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [OPCODE_LEN-1:0] OP_FETCH_A      = OPCODE_LEN'(1);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_B      = OPCODE_LEN'(2);
  localparam logic [OPCODE_LEN-1:0] OP_ADD          = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_SUB          = OPCODE_LEN'(4);
  localparam logic [OPCODE_LEN-1:0] OP_MUL          = OPCODE_LEN'(5);
  localparam logic [OPCODE_LEN-1:0] OP_DOTP         = OPCODE_LEN'(6);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_S1     = OPCODE_LEN'(7);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_S2     = OPCODE_LEN'(8);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_RESULT = OPCODE_LEN'(9);
  localparam logic [OPCODE_LEN-1:0] OP_STOP         = OPCODE_LEN'(10);
  localparam logic [OPCODE_LEN-1:0] OP_LOOP         = OPCODE_LEN'(11);
  localparam logic [OPCODE_LEN-1:0] OP_ENDLOOP      = OPCODE_LEN'(12);

  localparam logic [IAW-1:0] PC_LAST = IAW'(IMEM_DEPTH - 1);

  logic [INST_LEN-1:0] imem     [IMEM_DEPTH];
  logic [VEC_LEN-1:0]  bank_a   [DMEM_DEPTH];
  logic [VEC_LEN-1:0]  bank_b   [DMEM_DEPTH];
  logic [VEC_LEN-1:0]  res_bank [DMEM_DEPTH];

  logic [0:0]               state_q, state_d;
  logic [IAW-1:0]           pc_q, pc_d;
  logic [ADDR_LEN-1:0]      loop_cnt_q, loop_cnt_d;
  logic [IAW-1:0]           loop_pc_q, loop_pc_d;
  logic [DAW-1:0]           res_addr_q, res_addr_d;
  logic [PE_OPCODE_LEN-1:0] pe_opcode_q, pe_opcode_d;
  logic                     pe_opcode_valid_q, pe_opcode_valid_d;
  logic [VEC_LEN-1:0]       data_a_q, data_a_d;
  logic [VEC_LEN-1:0]       data_b_q, data_b_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [VEC_LEN-1:0]       result_q, result_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [DATA_LEN-1:0]      s2_data_q, s2_data_d;
  logic [VEC_LEN-1:0]       rd_data_q, rd_data_d;

  logic [OPCODE_LEN-1:0] opc;
  logic [ADDR_LEN-1:0]   operand;
  logic [DAW-1:0]        daddr;
  logic [IAW-1:0]        pc_next;
  logic                  jump;

  assign opc     = imem[pc_q][OPCODE_LEN-1:0];
  assign operand = imem[pc_q][OPCODE_LEN+ADDR_LEN-1:OPCODE_LEN];
  assign daddr   = operand[DAW-1:0];
  assign pc_next = pc_q + 1'b1;

  // Fetch/execute: one instruction consumed per cycle while running and the PE accepts.
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    loop_cnt_d        = loop_cnt_q;
    loop_pc_d         = loop_pc_q;
    res_addr_d        = res_addr_q;
    pe_opcode_d       = pe_opcode_q;
    pe_opcode_valid_d = 1'b0;
    data_a_d          = data_a_q;
    data_b_d          = data_b_q;
    done_d            = 1'b0;
    err_d             = err_q;
    jump              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        if (pe_ready) begin
          pe_opcode_valid_d = 1'b1;
          pe_opcode_d       = '0;
          pc_d              = pc_next;
          case (opc)
            OP_FETCH_A:  data_a_d = bank_a[daddr];
            OP_FETCH_B:  data_b_d = bank_b[daddr];
            OP_ADD:      pe_opcode_d = PE_OPCODE_LEN'(1);
            OP_SUB:      pe_opcode_d = PE_OPCODE_LEN'(2);
            OP_MUL:      pe_opcode_d = PE_OPCODE_LEN'(3);
            OP_DOTP:     pe_opcode_d = PE_OPCODE_LEN'(4);
            OP_STORE_S1: pe_opcode_d = PE_OPCODE_LEN'(5);
            OP_STORE_S2: pe_opcode_d = PE_OPCODE_LEN'(6);
            OP_STORE_RESULT: begin
              pe_opcode_d = PE_OPCODE_LEN'(7);
              res_addr_d  = daddr;
            end
            OP_STOP: begin
              pe_opcode_d = PE_OPCODE_LEN'(8);
              state_d     = ST_IDLE;
              done_d      = 1'b1;
            end
            OP_LOOP: begin
              loop_cnt_d = operand;
              loop_pc_d  = pc_next;
            end
            OP_ENDLOOP: begin
              if (loop_cnt_q != '0) begin
                loop_cnt_d = loop_cnt_q - 1'b1;
                pc_d       = loop_pc_q;
                jump       = 1'b1;
              end
            end
            default: ;
          endcase
          // Falling off the last program word without STOP aborts the run.
          if (opc != OP_STOP && !jump && pc_q == PC_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
    endcase
  end

  // Result register: commit beats capture; stage-2 scalars arrive one cycle late and shift in at lane 0.
  always_comb begin
    s2_valid_d = pe_stage_2_valid;
    s2_data_d  = pe_stage_2_output;
    rd_data_d  = res_bank[rd_addr];
    result_d   = result_q;
    if (!store_result) begin
      if (pe_stage_1_valid) begin
        result_d = pe_stage_1_output;
      end else if (s2_valid_q) begin
        result_d = {result_q[VEC_LEN-DATA_LEN-1:0], s2_data_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= ST_IDLE;
      pc_q              <= '0;
      loop_cnt_q        <= '0;
      loop_pc_q         <= '0;
      res_addr_q        <= '0;
      pe_opcode_q       <= '0;
      pe_opcode_valid_q <= 1'b0;
      data_a_q          <= '0;
      data_b_q          <= '0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      result_q          <= '0;
      s2_valid_q        <= 1'b0;
      s2_data_q         <= '0;
      rd_data_q         <= '0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      loop_cnt_q        <= loop_cnt_d;
      loop_pc_q         <= loop_pc_d;
      res_addr_q        <= res_addr_d;
      pe_opcode_q       <= pe_opcode_d;
      pe_opcode_valid_q <= pe_opcode_valid_d;
      data_a_q          <= data_a_d;
      data_b_q          <= data_b_d;
      done_q            <= done_d;
      err_q             <= err_d;
      result_q          <= result_d;
      s2_valid_q        <= s2_valid_d;
      s2_data_q         <= s2_data_d;
      rd_data_q         <= rd_data_d;
    end
  end

  // Storage arrays carry no reset; the host may only load them while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && mem_we) begin
      case (mem_sel)
        2'd0:    imem[mem_addr]          <= mem_wdata[INST_LEN-1:0];
        2'd1:    bank_a[mem_addr[DAW-1:0]] <= mem_wdata;
        2'd2:    bank_b[mem_addr[DAW-1:0]] <= mem_wdata;
        default: ;
      endcase
    end
    if (store_result) begin
      res_bank[res_addr_q] <= result_q;
    end
  end

  assign rd_data         = rd_data_q;
  assign pe_opcode       = pe_opcode_q;
  assign pe_opcode_valid = pe_opcode_valid_q;
  assign data_a          = data_a_q;
  assign data_b          = data_b_q;
  assign busy            = (state_q == ST_RUN);
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: directed programs push expected PE opcodes,
// a monitor pops and compares them whenever pe_opcode_valid is seen.
module tb_pe_sequencer;

  localparam int DL  = 32;
  localparam int VW  = 4 * DL;
  localparam int IAW = 7;
  localparam int DAW = 6;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           start = 1'b0;
  logic           pe_ready = 1'b1;
  logic           pe_stage_1_valid = 1'b0;
  logic [VW-1:0]  pe_stage_1_output = '0;
  logic           pe_stage_2_valid = 1'b0;
  logic [DL-1:0]  pe_stage_2_output = '0;
  logic           store_result = 1'b0;
  logic           mem_we = 1'b0;
  logic [1:0]     mem_sel = 2'd0;
  logic [IAW-1:0] mem_addr = '0;
  logic [VW-1:0]  mem_wdata = '0;
  logic [DAW-1:0] rd_addr = '0;
  logic [VW-1:0]  rd_data;
  logic [3:0]     pe_opcode;
  logic           pe_opcode_valid;
  logic [VW-1:0]  data_a;
  logic [VW-1:0]  data_b;
  logic           busy;
  logic           done;
  logic           err;

  pe_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .pe_ready(pe_ready),
    .pe_stage_1_valid(pe_stage_1_valid), .pe_stage_1_output(pe_stage_1_output),
    .pe_stage_2_valid(pe_stage_2_valid), .pe_stage_2_output(pe_stage_2_output),
    .store_result(store_result), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rd_addr(rd_addr), .rd_data(rd_data), .pe_opcode(pe_opcode),
    .pe_opcode_valid(pe_opcode_valid), .data_a(data_a), .data_b(data_b),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int issue_count = 0;
  int add_count = 0;
  int done_count = 0;
  int done_issue_count = 0;
  logic [3:0] exp_q [$];

  function automatic logic [VW-1:0] vec(input int a, input int b, input int c, input int d);
    return {a[DL-1:0], b[DL-1:0], c[DL-1:0], d[DL-1:0]};
  endfunction

  function automatic logic [VW-1:0] ins(input int opc, input int operand);
    logic [VW-1:0] w;
    w = '0;
    w[3:0]  = opc[3:0];
    w[11:4] = operand[7:0];
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input int addr, input logic [VW-1:0] data);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_sel   = sel;
    mem_addr  = addr[IAW-1:0];
    mem_wdata = data;
    @(posedge clk);
    #1 mem_we = 1'b0;
  endtask

  task automatic startProgram();
    @(negedge clk);
    issue_count = 0;
    add_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runUntilDone(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    #1;
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done within %0d cycles", name, budget);
    end
  endtask

  // Monitor: every valid PE opcode must match the oldest expected entry.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rstn && pe_opcode_valid) begin
        issue_count++;
        if (pe_opcode == 4'd1) add_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_issue actual=%0d required=none", pe_opcode);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pe_opcode", VW'(pe_opcode), VW'(e));
        end
      end
      if (done) begin
        done_count++;
        done_issue_count = issue_count;
      end
    end
  end

  initial begin
    int done_before;
    #3 rstn = 1'b0;
    #1;
    checkOutput("reset_valid", VW'(pe_opcode_valid), '0);
    checkOutput("reset_opcode", VW'(pe_opcode), '0);
    checkOutput("reset_data_a", data_a, '0);
    checkOutput("reset_busy", VW'(busy), '0);
    checkOutput("reset_done", VW'(done), '0);
    checkOutput("reset_err", VW'(err), '0);
    checkOutput("reset_rd_data", rd_data, '0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic fetch/add/stop.
    applyStimulus(2'd1, 3, vec(1, 2, 3, 4));
    applyStimulus(2'd2, 5, vec(1, 2, 3, 4));
    applyStimulus(2'd1, 7, vec(11, 12, 13, 14));
    applyStimulus(2'd0, 0, ins(1, 3));
    applyStimulus(2'd0, 1, ins(2, 5));
    applyStimulus(2'd0, 2, ins(3, 0));
    applyStimulus(2'd0, 3, ins(10, 0));
    exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd8);
    startProgram();
    checkOutput("run_busy", VW'(busy), 1);
    runUntilDone("basic", 50);
    checkOutput("basic_issues_at_done", VW'(done_issue_count), 4);
    checkOutput("basic_data_a", data_a, vec(1, 2, 3, 4));
    checkOutput("basic_data_b", data_b, vec(1, 2, 3, 4));
    checkOutput("basic_busy_after", VW'(busy), 0);
    checkOutput("basic_queue_empty", VW'(exp_q.size()), 0);
    @(negedge clk);
    checkOutput("basic_done_pulse", VW'(done), 0);

    // pe_ready stall for three cycles mid-program.
    applyStimulus(2'd0, 0, ins(1, 7));
    applyStimulus(2'd0, 1, ins(3, 0));
    applyStimulus(2'd0, 2, ins(4, 0));
    applyStimulus(2'd0, 3, ins(10, 0));
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd8);
    startProgram();
    @(negedge clk);
    @(negedge clk);
    pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", VW'(pe_opcode_valid), 0);
      checkOutput("stall_data_a", data_a, vec(11, 12, 13, 14));
      if (i == 2) pe_ready = 1'b1;
    end
    runUntilDone("stall", 50);
    checkOutput("stall_issues_at_done", VW'(done_issue_count), 4);
    checkOutput("stall_queue_empty", VW'(exp_q.size()), 0);

    // Hardware loop: body runs operand+1 times.
    applyStimulus(2'd0, 0, ins(11, 2));
    applyStimulus(2'd0, 1, ins(3, 0));
    applyStimulus(2'd0, 2, ins(12, 0));
    applyStimulus(2'd0, 3, ins(10, 0));
    exp_q.push_back(4'd0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd0);
    end
    exp_q.push_back(4'd8);
    startProgram();
    runUntilDone("loop", 60);
    checkOutput("loop_add_count", VW'(add_count), 3);
    checkOutput("loop_issues_at_done", VW'(done_issue_count), 8);
    checkOutput("loop_queue_empty", VW'(exp_q.size()), 0);

    // Result capture: stage-1 vector, two stage-2 scalars, commit to result bank 4.
    applyStimulus(2'd0, 0, ins(9, 4));
    applyStimulus(2'd0, 1, ins(10, 0));
    exp_q.push_back(4'd7); exp_q.push_back(4'd8);
    startProgram();
    runUntilDone("store", 50);
    @(negedge clk);
    pe_stage_1_valid = 1'b1;
    pe_stage_1_output = vec(5, 6, 7, 8);
    @(negedge clk);
    pe_stage_1_valid = 1'b0;
    pe_stage_2_valid = 1'b1;
    pe_stage_2_output = 32'd9;
    @(negedge clk);
    pe_stage_2_output = 32'd10;
    @(negedge clk);
    pe_stage_2_valid = 1'b0;
    @(negedge clk);
    store_result = 1'b1;
    @(negedge clk);
    store_result = 1'b0;
    rd_addr = 6'd4;
    @(negedge clk);
    checkOutput("result_bank4", rd_data, vec(7, 8, 9, 10));

    // Program with no STOP runs off the end of instruction memory.
    for (int a = 0; a < 128; a++) applyStimulus(2'd0, a, ins(0, 0));
    for (int a = 0; a < 128; a++) exp_q.push_back(4'd0);
    startProgram();
    runUntilDone("runoff", 400);
    checkOutput("runoff_err", VW'(err), 1);
    checkOutput("runoff_busy", VW'(busy), 0);
    checkOutput("runoff_issues", VW'(done_issue_count), 128);
    applyStimulus(2'd0, 0, ins(10, 0));
    exp_q.push_back(4'd8);
    startProgram();
    checkOutput("restart_err_cleared", VW'(err), 0);
    runUntilDone("restart", 50);
    checkOutput("restart_err_after", VW'(err), 0);

    // Host write during RUN is dropped, then reset lands mid-loop.
    applyStimulus(2'd0, 0, ins(11, 200));
    applyStimulus(2'd0, 1, ins(3, 0));
    applyStimulus(2'd0, 2, ins(12, 0));
    applyStimulus(2'd0, 3, ins(10, 0));
    exp_q.push_back(4'd0);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd0);
    end
    startProgram();
    repeat (3) @(negedge clk);
    applyStimulus(2'd1, 3, vec(99, 98, 97, 96));
    repeat (3) @(negedge clk);
    done_before = done_count;
    rstn = 1'b0;
    #1;
    checkOutput("midreset_valid", VW'(pe_opcode_valid), 0);
    checkOutput("midreset_opcode", VW'(pe_opcode), 0);
    checkOutput("midreset_data_a", data_a, '0);
    checkOutput("midreset_busy", VW'(busy), 0);
    checkOutput("midreset_done", VW'(done), 0);
    repeat (3) @(negedge clk);
    checkOutput("midreset_no_done", VW'(done_count), VW'(done_before));
    exp_q.delete();
    rstn = 1'b1;
    applyStimulus(2'd0, 0, ins(1, 3));
    applyStimulus(2'd0, 1, ins(10, 0));
    exp_q.push_back(4'd0); exp_q.push_back(4'd8);
    startProgram();
    runUntilDone("after_reset", 50);
    checkOutput("run_write_lost", data_a, vec(1, 2, 3, 4));
    checkOutput("final_queue_empty", VW'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
